// File: rtl/m_ucode_pkg.sv
// rtl/m_ucode_pkg.sv - shared microcode field positions, encodings and default addresses
package m_ucode_pkg;

   localparam int UWORD_W     = 48;
   localparam int NXT_LSB     = 0;
   localparam int NXT_W       = 8;
   localparam int SEQ_LSB_DEF = 8;
   localparam int SEQ_W       = 2;
   localparam int INSTR_W     = 10;
   localparam int SHAMT_W     = 5;

   localparam logic [7:0] BOOT_ADDR_DEF = 8'h00;
   localparam logic [7:0] IRQ_ADDR_DEF  = 8'hF8;
   localparam logic [7:0] TRAP_ADDR_DEF = 8'hFC;

   typedef enum logic [1:0] {
      SEQ_GOTO     = 2'b00,
      SEQ_DISPATCH = 2'b01,
      SEQ_WAIT     = 2'b10,
      SEQ_LOOP     = 2'b11
   } seq_e;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_LOOP = 2'b10
   } state_e;

   // instr is {opcode[6:0], funct3[2:0]}; only 32-bit encodings (opcode[1:0]==11) are legal
   function automatic logic instr_legal(input logic [INSTR_W-1:0] instr);
      return instr[4:3] == 2'b11;
   endfunction

   // Dispatch entry point: {opcode[6:2], funct3}
   function automatic logic [7:0] dispatch_addr(input logic [INSTR_W-1:0] instr);
      return {instr[9:5], instr[2:0]};
   endfunction

endpackage

// File: rtl/m_uloopcnt.sv
// rtl/m_uloopcnt.sv - 5-bit load/decrement shift-loop counter with zero flag
module m_uloopcnt
   import m_ucode_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [SHAMT_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [SHAMT_W-1:0] cnt_r;

   // Load has priority; decrement saturates at zero so the counter never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != '0)) begin
         cnt_r <= cnt_r - 1'b1;
      end
   end

   assign zero = (cnt_r == '0);

endmodule

// File: rtl/m_usequencer.sv
// rtl/m_usequencer.sv - microcode sequencer: next-address mux and boot/run/loop FSM
module m_usequencer
   import m_ucode_pkg::*;
#(
   parameter logic [7:0] BOOT_ADDR = BOOT_ADDR_DEF,
   parameter logic [7:0] IRQ_ADDR  = IRQ_ADDR_DEF,
   parameter logic [7:0] TRAP_ADDR = TRAP_ADDR_DEF,
   parameter int         SEQ_LSB   = SEQ_LSB_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [UWORD_W-1:0] d,
   input  logic [INSTR_W-1:0] instr,
   input  logic               irq_pending,
   input  logic               mie,
   input  logic               mem_ack,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [7:0]         minx,
   output logic               progress_ucode,
   output logic               shift_en,
   output logic               in_wait
);

   state_e             state_r;
   state_e             state_nxt;
   seq_e               seq;
   logic [NXT_W-1:0]   nxt;
   logic               cnt_load;
   logic               cnt_dec;
   logic               cnt_zero;
   logic               unused_d;

   assign seq      = seq_e'(d[SEQ_LSB+SEQ_W-1:SEQ_LSB]);
   assign nxt      = d[NXT_LSB+NXT_W-1:NXT_LSB];
   assign unused_d = ^d;

   // Loop counter holds the shifts remaining after the entry cycle
   m_uloopcnt u_loopcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (shamt - 5'd1),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register; reset returns to BOOT immediately, even mid-wait or mid-loop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BOOT;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and next-microaddress selection; minx defaults to nxt so stalls stay deterministic
   always_comb begin
      state_nxt      = state_r;
      minx           = nxt;
      progress_ucode = 1'b0;
      shift_en       = 1'b0;
      in_wait        = 1'b0;
      cnt_load       = 1'b0;
      cnt_dec        = 1'b0;
      case (state_r)
         ST_BOOT: begin
            minx           = BOOT_ADDR;
            progress_ucode = 1'b1;
            state_nxt      = ST_RUN;
         end
         ST_RUN: begin
            case (seq)
               SEQ_GOTO: begin
                  progress_ucode = 1'b1;
               end
               SEQ_DISPATCH: begin
                  progress_ucode = 1'b1;
                  if (irq_pending && mie) begin
                     minx = IRQ_ADDR;
                  end else if (!instr_legal(instr)) begin
                     minx = TRAP_ADDR;
                  end else begin
                     minx = dispatch_addr(instr);
                  end
               end
               SEQ_WAIT: begin
                  progress_ucode = mem_ack;
                  in_wait        = !mem_ack;
               end
               SEQ_LOOP: begin
                  if (shamt == '0) begin
                     progress_ucode = 1'b1;
                  end else begin
                     shift_en  = 1'b1;
                     cnt_load  = 1'b1;
                     state_nxt = ST_LOOP;
                  end
               end
               default: begin
                  progress_ucode = 1'b1;
               end
            endcase
         end
         ST_LOOP: begin
            if (!cnt_zero) begin
               shift_en = 1'b1;
               cnt_dec  = 1'b1;
            end else begin
               progress_ucode = 1'b1;
               state_nxt      = ST_RUN;
            end
         end
         default: begin
            minx           = BOOT_ADDR;
            progress_ucode = 1'b1;
            state_nxt      = ST_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_m_usequencer.sv
// tb/tb_m_usequencer.sv - directed and random self-checking bench for m_usequencer
module tb_m_usequencer;
   import m_ucode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [47:0] d;
   logic [9:0]  instr;
   logic        irq_pending;
   logic        mie;
   logic        mem_ack;
   logic [4:0]  shamt;
   logic [7:0]  minx;
   logic        progress_ucode;
   logic        shift_en;
   logic        in_wait;

   int checks = 0;
   int errors = 0;

   logic [47:0] rom [256];

   m_usequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .d              (d),
      .instr          (instr),
      .irq_pending    (irq_pending),
      .mie            (mie),
      .mem_ack        (mem_ack),
      .shamt          (shamt),
      .minx           (minx),
      .progress_ucode (progress_ucode),
      .shift_en       (shift_en),
      .in_wait        (in_wait)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] uw(input logic [1:0] s, input logic [7:0] n);
      return {38'd0, s, n};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] em, input logic ep, input logic es,
                      input logic ew);
      checks++;
      assert (minx === em) else begin
         errors++;
         $error("FAIL %s minx obs=%h exp=%h", tag, minx, em);
      end
      checks++;
      assert (progress_ucode === ep) else begin
         errors++;
         $error("FAIL %s progress_ucode obs=%b exp=%b", tag, progress_ucode, ep);
      end
      checks++;
      assert (shift_en === es) else begin
         errors++;
         $error("FAIL %s shift_en obs=%b exp=%b", tag, shift_en, es);
      end
      checks++;
      assert (in_wait === ew) else begin
         errors++;
         $error("FAIL %s in_wait obs=%b exp=%b", tag, in_wait, ew);
      end
   endtask

   // Reference model state: boot pending flag and number of shift cycles still owed
   bit          m_boot;
   bit          m_looping;
   int          m_left;
   logic [47:0] m_dreg;

   initial begin
      rst_n       = 1'b0;
      d           = '0;
      instr       = '0;
      irq_pending = 1'b0;
      mie         = 1'b0;
      mem_ack     = 1'b0;
      shamt       = '0;

      // Boot: three cycles in reset, then first run cycle
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("reset", 8'h00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      rst_n = 1'b1;
      mid();
      chk("boot", 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      d = uw(2'b00, 8'h05);
      mid();
      chk("goto05", 8'h05, 1'b1, 1'b0, 1'b0);
      tick();

      // Dispatch priority
      d     = uw(2'b01, 8'h77);
      instr = {7'b0110011, 3'b101};
      mid();
      chk("disp_legal", 8'h65, 1'b1, 1'b0, 1'b0);
      tick();
      irq_pending = 1'b1;
      mie         = 1'b1;
      mid();
      chk("disp_irq", 8'hF8, 1'b1, 1'b0, 1'b0);
      tick();
      mie = 1'b0;
      mid();
      chk("disp_irq_masked", 8'h65, 1'b1, 1'b0, 1'b0);
      tick();
      irq_pending = 1'b0;
      instr       = {7'b0110001, 3'b000};
      mid();
      chk("disp_illegal", 8'hFC, 1'b1, 1'b0, 1'b0);
      tick();
      irq_pending = 1'b1;
      mie         = 1'b1;
      mid();
      chk("disp_irq_over_illegal", 8'hF8, 1'b1, 1'b0, 1'b0);
      tick();
      irq_pending = 1'b0;
      mie         = 1'b0;

      // Wait: four stalled cycles then ack; then zero-stall ack
      d       = uw(2'b10, 8'h21);
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("wait_stall", 8'h21, 1'b0, 1'b0, 1'b1);
         tick();
      end
      mem_ack = 1'b1;
      mid();
      chk("wait_ack", 8'h21, 1'b1, 1'b0, 1'b0);
      tick();
      d = uw(2'b10, 8'h33);
      mid();
      chk("wait_nostall", 8'h33, 1'b1, 1'b0, 1'b0);
      tick();
      mem_ack = 1'b0;

      // Loop shamt=5, shamt disturbed mid-loop
      d     = uw(2'b11, 8'h40);
      shamt = 5'd5;
      for (int i = 1; i <= 5; i++) begin
         if (i == 3) shamt = 5'd2;
         mid();
         chk("loop5_shift", 8'h40, 1'b0, 1'b1, 1'b0);
         tick();
      end
      mid();
      chk("loop5_done", 8'h40, 1'b1, 1'b0, 1'b0);
      tick();

      // Loop shamt=0 behaves as goto
      d     = uw(2'b11, 8'h41);
      shamt = 5'd0;
      mid();
      chk("loop0", 8'h41, 1'b1, 1'b0, 1'b0);
      tick();

      // Loop shamt=31: 31 shifts then advance
      d     = uw(2'b11, 8'h42);
      shamt = 5'd31;
      for (int i = 1; i <= 31; i++) begin
         if (i == 10) shamt = 5'd3;
         mid();
         chk("loop31_shift", 8'h42, 1'b0, 1'b1, 1'b0);
         tick();
      end
      mid();
      chk("loop31_done", 8'h42, 1'b1, 1'b0, 1'b0);
      tick();

      // Asynchronous reset at the third shift cycle
      d     = uw(2'b11, 8'h40);
      shamt = 5'd5;
      tick();
      tick();
      mid();
      chk("rst_loop_pre", 8'h40, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_loop_async", 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      mid();
      chk("rst_loop_hold", 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      d     = uw(2'b11, 8'h40);
      mid();
      chk("reboot", 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      d = uw(2'b00, 8'h05);
      mid();
      chk("reboot_goto05", 8'h05, 1'b1, 1'b0, 1'b0);
      tick();

      // Random microprogram driven through a ROM model
      for (int i = 0; i < 256; i++) begin
         rom[i] = {6'd0, 32'($urandom()), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      end
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      m_boot    = 1'b1;
      m_looping = 1'b0;
      m_left    = 0;
      m_dreg    = rom[8'($urandom_range(0, 255))];
      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic [7:0] em;
         logic       ep;
         logic       es;
         logic       ew;
         logic [6:0] opcode;
         int         r;
         d           = m_dreg;
         instr       = 10'($urandom_range(0, 1023));
         irq_pending = 1'($urandom_range(0, 1));
         mie         = 1'($urandom_range(0, 1));
         mem_ack     = ($urandom_range(0, 2) != 0);
         r           = $urandom_range(0, 7);
         shamt       = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 30));
         mid();
         em     = d[7:0];
         ep     = 1'b0;
         es     = 1'b0;
         ew     = 1'b0;
         opcode = instr[9:3];
         if (m_boot) begin
            em     = 8'h00;
            ep     = 1'b1;
            m_boot = 1'b0;
         end else if (m_looping) begin
            if (m_left > 0) begin
               es = 1'b1;
               m_left--;
            end else begin
               ep        = 1'b1;
               m_looping = 1'b0;
            end
         end else begin
            case (d[9:8])
               2'b00: ep = 1'b1;
               2'b01: begin
                  ep = 1'b1;
                  if (irq_pending && mie) em = 8'hF8;
                  else if (opcode[1:0] != 2'b11) em = 8'hFC;
                  else em = {opcode[6:2], instr[2:0]};
               end
               2'b10: begin
                  ep = mem_ack;
                  ew = !mem_ack;
               end
               default: begin
                  if (shamt == 0) begin
                     ep = 1'b1;
                  end else begin
                     es        = 1'b1;
                     m_looping = 1'b1;
                     m_left    = int'(shamt) - 1;
                  end
               end
            endcase
         end
         chk("random", em, ep, es, ew);
         if (ep) m_dreg = rom[em];
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
